// File: rtl/fm_pkg.sv
// Shared FM sizing constants and types used by the slot sequencer and the phase generator.
package fm_pkg;

  localparam int unsigned FM_NUM_OPS = 36;
  localparam int unsigned FM_OP_W    = 6;
  localparam int unsigned FM_VIB_W   = 3;

  typedef logic [FM_OP_W-1:0]  op_idx_t;
  typedef logic [FM_VIB_W-1:0] vib_pos_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/fm_slot_sequencer_if.sv
// Bundle of the slot sequencer's control and status signals; master drives ticks and key-ons.
interface fm_slot_sequencer_if
  import fm_pkg::*;
();

  logic     sample_tick;
  logic     keyon_set;
  op_idx_t  keyon_op;
  op_idx_t  op_sel;
  logic     next;
  logic     restart;
  vib_pos_t vib_pos;
  logic     busy;
  logic     frame_done;
  logic     overrun;

  modport master (
    output sample_tick, keyon_set, keyon_op,
    input  op_sel, next, restart, vib_pos, busy, frame_done, overrun
  );

  modport slave (
    input  sample_tick, keyon_set, keyon_op,
    output op_sel, next, restart, vib_pos, busy, frame_done, overrun
  );

endinterface

// File: rtl/fm_lfo_div.sv
// Frame-rate divider: counts completed frames and steps the 3-bit vibrato position on each wrap.
module fm_lfo_div
  import fm_pkg::*;
#(
  parameter int unsigned VIB_DIV_LOG2 = 10
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     frame_done,
  output vib_pos_t vib_pos
);

  logic [VIB_DIV_LOG2-1:0] cnt_q, cnt_d;
  vib_pos_t                vib_q, vib_d;

  always_comb begin
    cnt_d = cnt_q;
    vib_d = vib_q;
    if (frame_done) begin
      cnt_d = cnt_q + VIB_DIV_LOG2'(1);
      if (&cnt_q) begin
        vib_d = vib_q + vib_pos_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      vib_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vib_q <= vib_d;
    end
  end

  assign vib_pos = vib_q;

endmodule

// File: rtl/fm_slot_sequencer.sv
// Walks the operator slots once per sample frame, issuing commit strobes and phase restarts
// for operators with a pending key-on.
module fm_slot_sequencer
  import fm_pkg::*;
#(
  parameter int unsigned NUM_OPS      = FM_NUM_OPS,
  parameter int unsigned SLOT_CYCLES  = 4,
  parameter int unsigned VIB_DIV_LOG2 = 10
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     sample_tick,
  input  logic     keyon_set,
  input  op_idx_t  keyon_op,
  output op_idx_t  op_sel,
  output logic     next,
  output logic     restart,
  output vib_pos_t vib_pos,
  output logic     busy,
  output logic     frame_done,
  output logic     overrun
);

  localparam int unsigned     CYC_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);
  localparam op_idx_t          OP_LAST  = op_idx_t'(NUM_OPS - 1);

  seq_state_t         state_q, state_d;
  op_idx_t            op_q, op_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [NUM_OPS-1:0] pend_q, pend_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic               commit;
  logic               key_valid;
  logic               key_hit;
  logic               restart_c;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cyc_d     = cyc_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q;
    commit    = (state_q == RUN) && (cyc_q == CYC_LAST);
    key_valid = keyon_set && (32'(keyon_op) < NUM_OPS);
    key_hit   = keyon_set && (keyon_op == op_q);
    restart_c = commit && (pend_q[op_q] || key_hit);

    // Clear after set so a same-cycle key-on on the committing slot is consumed by this restart.
    if (key_valid) pend_d[keyon_op] = 1'b1;
    if (commit)    pend_d[op_q]     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The frame_done clock still counts as the tail of the previous frame.
        if (sample_tick && !done_q) begin
          state_d = RUN;
          op_d    = '0;
          cyc_d   = '0;
        end
      end
      RUN: begin
        if (sample_tick) ovr_d = 1'b1;
        if (commit) begin
          cyc_d = '0;
          if (op_q == OP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            op_d = op_q + op_idx_t'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cyc_q   <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cyc_q   <= cyc_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  fm_lfo_div #(
    .VIB_DIV_LOG2(VIB_DIV_LOG2)
  ) u_lfo_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_done (done_q),
    .vib_pos    (vib_pos)
  );

  assign op_sel     = op_q;
  assign next       = commit;
  assign restart    = restart_c;
  assign busy       = (state_q == RUN);
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_fm_slot_sequencer.sv
// Scoreboard bench for fm_slot_sequencer: a frame-level reference model queues expected commits,
// frame ends and per-cycle status; a negedge monitor pops and compares.
module tb_fm_slot_sequencer;
  import fm_pkg::*;

  localparam int unsigned N  = 36;
  localparam int unsigned SC = 4;
  localparam int unsigned L  = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fm_slot_sequencer_if bus();

  fm_slot_sequencer #(
    .NUM_OPS(N),
    .SLOT_CYCLES(SC),
    .VIB_DIV_LOG2(L)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (bus.sample_tick),
    .keyon_set   (bus.keyon_set),
    .keyon_op    (bus.keyon_op),
    .op_sel      (bus.op_sel),
    .next        (bus.next),
    .restart     (bus.restart),
    .vib_pos     (bus.vib_pos),
    .busy        (bus.busy),
    .frame_done  (bus.frame_done),
    .overrun     (bus.overrun)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned cyc;
    bit          done;
    int unsigned op;
    bit          rst;
  } ev_t;

  typedef struct {
    bit          busy;
    int unsigned op;
    bit          ovr;
    int unsigned vib;
  } st_t;

  ev_t evq[$];
  st_t stq[$];
  int unsigned cur_cyc = 0;

  // Reference model: frame position as a single cycle index, pending key-ons as a bit array.
  bit          m_busy, m_fd, m_ovr;
  int unsigned m_t, m_last, m_fdcount;
  bit          m_pend [N];

  task automatic model_reset();
    m_busy = 0; m_fd = 0; m_ovr = 0;
    m_t = 0; m_last = 0; m_fdcount = 0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    evq.delete();
    stq.delete();
  endtask

  task automatic step(input bit tk, input bit ks, input int unsigned ko);
    int unsigned op;
    bit          commit;
    bit          fd_now;
    cur_cyc++;
    fd_now = m_fd;
    op     = m_busy ? (m_t / SC) : m_last;
    commit = m_busy && ((m_t % SC) == SC - 1);
    stq.push_back('{m_busy, op, m_ovr, (m_fdcount >> L) % 8});
    if (commit) evq.push_back('{cur_cyc, 1'b0, op, m_pend[op] || (ks && ko == op)});
    if (fd_now) evq.push_back('{cur_cyc, 1'b1, 0, 1'b0});
    if (ks && ko < N) m_pend[ko] = 1;
    if (commit) m_pend[op] = 0;
    if (fd_now) m_fdcount++;
    if (tk && m_busy) m_ovr = 1;
    if (m_busy) begin
      m_last = op;
      m_fd   = 0;
      if (commit && op == N - 1) begin
        m_busy = 0;
        m_fd   = 1;
      end else begin
        m_t++;
      end
    end else begin
      m_fd = 0;
      if (tk && !fd_now) begin
        m_busy = 1;
        m_t    = 0;
      end
    end
  endtask

  task automatic drive(input bit tk, input bit ks, input int unsigned ko);
    @(posedge clk);
    #2;
    bus.sample_tick = tk;
    bus.keyon_set   = ks;
    bus.keyon_op    = 6'(ko);
    step(tk, ks, ko);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while ((m_busy || m_fd) && k < 1000) begin
      drive(0, 0, 0);
      k++;
    end
    if (m_busy || m_fd) begin
      checks++;
      failures++;
      $display("FAIL wait_idle timeout got busy=%b required idle", bus.busy);
    end
  endtask

  task automatic check_zero(input string name);
    logic [19:0] got;
    got = {bus.busy, bus.next, bus.restart, bus.frame_done, bus.overrun, bus.vib_pos, bus.op_sel, 5'b0};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL %s got busy=%b next=%b restart=%b done=%b ovr=%b vib=%0d op=%0d required all 0",
               name, bus.busy, bus.next, bus.restart, bus.frame_done, bus.overrun, bus.vib_pos, bus.op_sel);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset_n         = 1'b1;
    bus.sample_tick = 1'b0;
    bus.keyon_set   = 1'b0;
    bus.keyon_op    = '0;
    step(0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    st_t s;
    ev_t e;
    if (reset_n === 1'b1) begin
      if (stq.size() > 0) begin
        s = stq.pop_front();
        checks++;
        if (bus.busy !== s.busy || bus.op_sel !== 6'(s.op) || bus.overrun !== s.ovr ||
            bus.vib_pos !== 3'(s.vib) || (bus.restart === 1'b1 && bus.next !== 1'b1)) begin
          failures++;
          $display("FAIL status cyc=%0d got busy=%b op=%0d ovr=%b vib=%0d rst=%b nxt=%b required busy=%b op=%0d ovr=%b vib=%0d",
                   cur_cyc, bus.busy, bus.op_sel, bus.overrun, bus.vib_pos, bus.restart, bus.next,
                   s.busy, s.op, s.ovr, s.vib);
        end
      end
      while (evq.size() > 0 && evq[0].cyc < cur_cyc) begin
        e = evq.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_event got none at cyc=%0d required done=%b op=%0d restart=%b",
                 e.cyc, e.done, e.op, e.rst);
      end
      if (bus.next === 1'b1 || bus.frame_done === 1'b1) begin
        checks++;
        if (evq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d got next=%b done=%b op=%0d required nothing",
                   cur_cyc, bus.next, bus.frame_done, bus.op_sel);
        end else begin
          e = evq.pop_front();
          if (e.cyc != cur_cyc || bus.frame_done !== e.done || bus.next !== !e.done ||
              (!e.done && (bus.op_sel !== 6'(e.op) || bus.restart !== e.rst))) begin
            failures++;
            $display("FAIL event cyc=%0d got next=%b done=%b op=%0d restart=%b required cyc=%0d done=%b op=%0d restart=%b",
                     cur_cyc, bus.next, bus.frame_done, bus.op_sel, bus.restart,
                     e.cyc, e.done, e.op, e.rst);
          end
        end
      end
    end
  end

  initial begin
    int unsigned guard;
    reset_n         = 1'b0;
    bus.sample_tick = 1'b0;
    bus.keyon_set   = 1'b0;
    bus.keyon_op    = '0;
    model_reset();
    #3;
    check_zero("reset_init");
    repeat (2) @(posedge clk);
    release_reset();
    idle(3);

    // Plain frame: 36 commits, no restarts.
    drive(1, 0, 0);
    wait_idle();
    idle(2);

    // Key-on while idle, serviced once.
    drive(0, 1, 5);
    drive(1, 0, 0);
    wait_idle();
    drive(1, 0, 0);
    wait_idle();

    // Key-on coinciding with slot 7's commit.
    drive(1, 0, 0);
    idle(31);
    drive(0, 1, 7);
    wait_idle();
    drive(1, 0, 0);
    wait_idle();

    // Tick during the frame_done clock is ignored and does not flag overrun.
    drive(1, 0, 0);
    guard = 0;
    while (!m_fd && guard < 400) begin
      drive(0, 0, 0);
      guard++;
    end
    drive(1, 0, 0);
    idle(3);

    // Out-of-range key-on, then an overrunning tick mid-frame.
    drive(0, 1, 40);
    drive(1, 0, 0);
    idle(50);
    drive(1, 0, 0);
    wait_idle();
    checks++;
    if (bus.overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got %b required 1", bus.overrun);
    end

    // Back-to-back frames with random key-ons and stray ticks; carries vib_pos through a full wrap.
    guard = 0;
    while (m_fdcount < 72 && guard < 15000) begin
      bit          tk;
      bit          ks;
      int unsigned ko;
      tk = (!m_busy && !m_fd) || ($urandom_range(0, 199) == 0);
      ks = ($urandom_range(0, 15) == 0);
      ko = $urandom_range(0, 47);
      drive(tk, ks, ko);
      guard++;
    end
    checks++;
    if (m_fdcount < 72) begin
      failures++;
      $display("FAIL frame_budget got %0d frames required 72", m_fdcount);
    end
    wait_idle();

    // Asynchronous reset mid-frame at op_sel 20.
    drive(1, 0, 0);
    idle(81);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid");
    model_reset();
    repeat (3) @(posedge clk);
    release_reset();
    idle(20);
    drive(1, 1, 3);
    wait_idle();
    idle(2);

    checks++;
    if (evq.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got %0d required 0", evq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fm_slot_sequencer.md
FM_SLOT_SEQUENCER -- requirements
Module: fm_slot_sequencer

Interface
REQ-001 SHALL have parameter NUM_OPS, default 36: operator slots serviced per sample frame.
REQ-002 SHALL have parameter SLOT_CYCLES, default 4: clocks spent per slot (minimum 2).
REQ-003 SHALL have parameter VIB_DIV_LOG2, default 10: log2 of samples per vibrato position step.
REQ-004 SHALL have port clk, input, 1: single system clock, all logic rising-edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sample_tick, input, 1: one-clock pulse starting a sample frame.
REQ-007 SHALL have port keyon_set, input, 1: one-clock pulse requesting phase restart of operator keyon_op.
REQ-008 SHALL have port keyon_op, input, 6: operator index for keyon_set.
REQ-009 SHALL have port op_sel, output, 6: operator slot currently addressed in the phase/envelope RAMs.
REQ-010 SHALL have port next, output, 1: commit strobe for the addressed slot's accumulator write.
REQ-011 SHALL have port restart, output, 1: zero the addressed slot's phase before adding the increment; valid only with next.
REQ-012 SHALL have port vib_pos, output, 3: vibrato position 0..7.
REQ-013 SHALL have port busy, output, 1: high while a frame is in progress.
REQ-014 SHALL have port frame_done, output, 1: one-clock pulse after the last slot commits.
REQ-015 SHALL have port overrun, output, 1: sticky flag, sample_tick received while busy.

Function
REQ-016 FSM states SHALL be IDLE and RUN; IDLE->RUN on sample_tick; RUN->IDLE on the clock after the commit of slot NUM_OPS-1.
REQ-017 On entering RUN, op_sel SHALL be 0 and slot cycle counter 0, both valid the clock after sample_tick.
REQ-018 Each slot SHALL last exactly SLOT_CYCLES clocks; next SHALL be high only in the last clock of each slot.
REQ-019 After a commit, op_sel SHALL advance by 1 (or the frame SHALL end if op_sel = NUM_OPS-1); a frame therefore takes NUM_OPS*SLOT_CYCLES clocks of busy.
REQ-020 frame_done SHALL pulse in the first IDLE clock after the final commit; busy SHALL be low in that clock.
REQ-021 A per-operator pending vector (NUM_OPS bits) SHALL be set by keyon_set at index keyon_op; keyon_op >= NUM_OPS SHALL be ignored.
REQ-022 restart SHALL equal next AND (pending[op_sel] OR (keyon_set AND keyon_op = op_sel)).
REQ-023 pending[op_sel] SHALL clear on the commit clock, also when a same-cycle keyon_set targets that slot (restart already asserted).
REQ-024 keyon_set for a slot not being committed SHALL set its pending bit regardless of FSM state; it is serviced at that slot's next commit.
REQ-025 sample_tick while busy, including the frame_done clock, SHALL be ignored; it SHALL set overrun only while busy.
REQ-026 A sample counter of VIB_DIV_LOG2 bits SHALL increment at each frame end; vib_pos SHALL increment (mod 8) when the counter wraps from all-ones to 0.
REQ-027 op_sel SHALL hold its last value while IDLE; next and restart SHALL be 0 while IDLE.

Reset
REQ-028 Asserting reset_n low SHALL asynchronously force IDLE, op_sel 0, next 0, restart 0, vib_pos 0, sample counter 0, pending all 0, busy 0, frame_done 0, overrun 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no further commit; the first frame after release SHALL begin only on a new sample_tick.

Structure
REQ-030 NUM_OPS default, op index width and vib_pos width SHALL live in shared package fm_pkg, used by this block and the phase generator.
REQ-031 The sample counter and vib_pos stepping SHALL be one sub-module fm_lfo_div (input frame_done, output vib_pos); the FSM and pending vector SHALL remain in this module.

Verification
REQ-032 One sample_tick after reset -> busy for 144 clocks, op_sel 0..35, 36 next pulses each 4 clocks apart, frame_done once, restart never.
REQ-033 keyon_set op 5 while IDLE, then sample_tick -> restart high only with the op_sel=5 commit; next frame, no restart.
REQ-034 keyon_set op 7 in the same clock as the op_sel=7 commit -> restart high that clock; next frame, no restart for op 7.
REQ-035 keyon_op=40 pulse -> no restart in the following frame; a second sample_tick mid-frame -> overrun=1, frame length unchanged.
REQ-036 1024 complete frames -> vib_pos 0->1 on the 1024th frame_done; 8192 frames -> vib_pos wraps back to 0.
REQ-037 reset_n low at op_sel=20 mid-frame -> all outputs 0 immediately; after release, no next pulse until the next sample_tick.
